// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetch and MEM load/store, one transaction outstanding; define ARB_STARVE_GUARD_EN for the IF starvation guard
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W = 32
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_if_req,
  input  logic [31:0]         i_if_addr,
  input  logic                i_if_flush,
  output logic                o_if_ready,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_wr,
  input  logic [31:0]         i_d_addr,
  input  logic [DATA_W-1:0]   i_d_wdata,
  input  logic [DATA_W/8-1:0] i_d_wstrb,
  output logic                o_d_ready,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_m_req,
  output logic                o_m_wr,
  output logic [31:0]         o_m_addr,
  output logic [DATA_W-1:0]   o_m_wdata,
  output logic [DATA_W/8-1:0] o_m_wstrb,
  input  logic                i_m_ack,
  input  logic                i_m_rvalid,
  input  logic [DATA_W-1:0]   i_m_rdata
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT out of range 1..15");
  end
  state_t              r_state;
  logic                r_owner_if;
  logic                r_drop;
  logic                r_m_wr;
  logic [31:0]         r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic [DATA_W/8-1:0] r_m_wstrb;
  logic                w_idle;
  logic                w_rsp;
  logic                w_if_elig;
  logic                w_if_force;
  logic                w_grant_d;
  logic                w_grant_if;
  assign w_idle     = i_reset_n && r_state == S_IDLE;
  assign w_rsp      = i_reset_n && r_state == S_WAIT && i_m_rvalid;
  assign w_if_elig  = i_if_req && !i_if_flush;
  assign w_grant_d  = w_idle && i_d_req && !w_if_force;
  assign w_grant_if = w_idle && w_if_elig && !w_grant_d;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] r_starve;
  assign w_if_force = r_starve == 4'(STARVE_LIMIT) && w_if_elig;
  // count data grants that bypassed a waiting fetch; an IF grant or an idle cycle without a fetch resets it
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_starve <= '0;
    else if (r_state == S_IDLE) begin
      if (w_grant_if || !i_if_req) r_starve <= '0;
      else if (w_grant_d && !i_if_flush && r_starve != 4'(STARVE_LIMIT)) r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_if_force = 1'b0;
`endif
  // transaction sequencer: grant and latch in IDLE, hold request until ack, await response
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_owner_if <= 1'b0;
      r_drop     <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_grant_d || w_grant_if) begin
          r_state    <= S_REQ;
          r_owner_if <= w_grant_if;
          r_m_wr     <= w_grant_d && i_d_wr;
          r_m_addr   <= w_grant_d ? i_d_addr : i_if_addr;
          r_m_wdata  <= w_grant_d ? i_d_wdata : '0;
          r_m_wstrb  <= w_grant_d ? i_d_wstrb : '0;
        end
        S_REQ: begin
          if (i_m_ack) r_state <= S_WAIT;
          if (r_owner_if && i_if_flush) r_drop <= 1'b1;
        end
        S_WAIT: begin
          if (i_m_rvalid) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
          end else if (r_owner_if && i_if_flush) r_drop <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_if_ready  = w_grant_if;
  assign o_d_ready   = w_grant_d;
  assign o_m_req     = r_state == S_REQ;
  assign o_m_wr      = r_m_wr;
  assign o_m_addr    = r_m_addr;
  assign o_m_wdata   = r_m_wdata;
  assign o_m_wstrb   = r_m_wstrb;
  assign o_if_rvalid = w_rsp && r_owner_if && !r_drop;
  assign o_d_rvalid  = w_rsp && !r_owner_if;
  assign o_if_rdata  = o_if_rvalid ? i_m_rdata : '0;
  assign o_d_rdata   = (o_d_rvalid && !r_m_wr) ? i_m_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized transactions against a transaction-level model
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk, rst_n;
  logic if_req, if_flush, if_ready, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic d_req, d_wr, d_ready, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0] d_wstrb;
  logic m_req, m_wr, m_ack, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0] m_wstrb;
  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
    .o_if_ready(if_ready), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
    .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_wstrb(d_wstrb),
    .o_d_ready(d_ready), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
    .o_m_req(m_req), .o_m_wr(m_wr), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb),
    .i_m_ack(m_ack), .i_m_rvalid(m_rvalid), .i_m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  task automatic serve;
    @(negedge clk); if_req = 0; d_req = 0; m_rvalid = 0; m_ack = 1;
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 32'h0BADF00D;
    @(negedge clk); m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; if_req = 1; d_req = 1; m_ack = 1; m_rvalid = 1; m_rdata = '1; if_flush = 0;
    if_addr = 32'h1C000000; d_addr = 32'h1C001000; d_wr = 1; d_wdata = '1; d_wstrb = '1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if ({if_ready, d_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b exp 00", {if_ready, d_ready}); end
    n_cmp++; if ({m_req, m_wr, m_addr, m_wdata, m_wstrb} !== 70'h0) begin n_err++; $display("FAIL reset_mem: got req=%b wr=%b addr=%h wdata=%h wstrb=%h exp all 0", m_req, m_wr, m_addr, m_wdata, m_wstrb); end
    n_cmp++; if ({if_rvalid, d_rvalid, if_rdata, d_rdata} !== 66'h0) begin n_err++; $display("FAIL reset_rsp: got ifv=%b dv=%b ifd=%h dd=%h exp all 0", if_rvalid, d_rvalid, if_rdata, d_rdata); end
    @(negedge clk);
    rst_n = 1; if_req = 0; d_req = 0; m_ack = 0; m_rvalid = 0; m_rdata = 0; d_wr = 0;
  endtask

  task automatic test_lone_fetch;
    @(negedge clk); if_req = 1; if_addr = 32'h1C000000; #1;
    n_cmp++; if ({if_ready, d_ready} !== 2'b10) begin n_err++; $display("FAIL fetch_grant: got %b exp 10", {if_ready, d_ready}); end
    @(negedge clk); if_req = 0; m_ack = 1; #1;
    n_cmp++; if ({m_req, m_wr, m_addr} !== {2'b10, 32'h1C000000}) begin n_err++; $display("FAIL fetch_req: got req=%b wr=%b addr=%h exp 1 0 1c000000", m_req, m_wr, m_addr); end
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 32'h02800000; d_req = 1; d_wr = 0; d_addr = 32'h1C001000; #1;
    n_cmp++; if ({if_rvalid, if_rdata, d_rvalid, d_ready} !== {1'b1, 32'h02800000, 2'b00}) begin n_err++; $display("FAIL fetch_rsp: got ifv=%b ifd=%h dv=%b drdy=%b exp 1 02800000 0 0", if_rvalid, if_rdata, d_rvalid, d_ready); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0; #1;
    n_cmp++; if ({d_ready, m_req, if_rvalid} !== 3'b100) begin n_err++; $display("FAIL issue_interval: got drdy=%b mreq=%b ifv=%b exp 1 0 0", d_ready, m_req, if_rvalid); end
    serve();
  endtask

  task automatic test_collision;
    @(negedge clk); if_req = 1; if_addr = 32'h1C000080; d_req = 1; d_wr = 0; d_addr = 32'h1C001000; #1;
    n_cmp++; if ({if_ready, d_ready} !== 2'b01) begin n_err++; $display("FAIL collision_grant: got %b exp 01", {if_ready, d_ready}); end
    @(negedge clk); d_req = 0; m_ack = 1; #1;
    n_cmp++; if ({m_req, m_wr, m_addr, if_ready} !== {2'b10, 32'h1C001000, 1'b0}) begin n_err++; $display("FAIL collision_req: got req=%b wr=%b addr=%h ifrdy=%b exp 1 0 1c001000 0", m_req, m_wr, m_addr, if_ready); end
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 32'h12345678; #1;
    n_cmp++; if ({d_rvalid, d_rdata, if_rvalid, if_ready} !== {1'b1, 32'h12345678, 2'b00}) begin n_err++; $display("FAIL collision_rsp: got dv=%b dd=%h ifv=%b ifrdy=%b exp 1 12345678 0 0", d_rvalid, d_rdata, if_rvalid, if_ready); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0; #1;
    n_cmp++; if ({if_ready, d_ready} !== 2'b10) begin n_err++; $display("FAIL collision_if_after: got %b exp 10", {if_ready, d_ready}); end
    serve();
  endtask

  task automatic test_flush_drop;
    @(negedge clk); if_req = 1; if_flush = 1; if_addr = 32'h1C000020; #1;
    n_cmp++; if (if_ready !== 1'b0) begin n_err++; $display("FAIL flush_idle: got ifrdy=%b exp 0", if_ready); end
    @(negedge clk); if_flush = 0; #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL flush_grant: got ifrdy=%b exp 1", if_ready); end
    @(negedge clk); if_req = 0; m_ack = 1;
    @(negedge clk); m_ack = 0; if_flush = 1;
    @(negedge clk); if_flush = 0; m_rvalid = 1; m_rdata = 32'hAAAA5555; #1;
    n_cmp++; if ({if_rvalid, if_rdata, d_rvalid} !== 34'h0) begin n_err++; $display("FAIL flush_drop: got ifv=%b ifd=%h dv=%b exp 0 0 0", if_rvalid, if_rdata, d_rvalid); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0; if_req = 1; if_addr = 32'h1C000040; #1;
    n_cmp++; if (if_ready !== 1'b1) begin n_err++; $display("FAIL refetch_grant: got ifrdy=%b exp 1", if_ready); end
    @(negedge clk); if_req = 0; m_ack = 1; #1;
    n_cmp++; if ({m_req, m_addr} !== {1'b1, 32'h1C000040}) begin n_err++; $display("FAIL refetch_req: got req=%b addr=%h exp 1 1c000040", m_req, m_addr); end
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 32'h0000BBBB; #1;
    n_cmp++; if ({if_rvalid, if_rdata} !== {1'b1, 32'h0000BBBB}) begin n_err++; $display("FAIL refetch_rsp: got ifv=%b ifd=%h exp 1 0000bbbb", if_rvalid, if_rdata); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic test_store_delay;
    @(negedge clk); d_req = 1; d_wr = 1; d_addr = 32'h1C002000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF; #1;
    n_cmp++; if ({if_ready, d_ready} !== 2'b01) begin n_err++; $display("FAIL store_grant: got %b exp 01", {if_ready, d_ready}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); d_req = 0; d_wr = 0; d_wdata = 0; d_wstrb = 0; m_ack = (i == 3); #1;
      n_cmp++;
      if ({m_req, m_wr, m_addr, m_wdata, m_wstrb} !== {2'b11, 32'h1C002000, 32'hDEADBEEF, 4'hF}) begin
        n_err++; $display("FAIL store_hold[%0d]: got req=%b wr=%b addr=%h wdata=%h wstrb=%h exp 1 1 1c002000 deadbeef f", i, m_req, m_wr, m_addr, m_wdata, m_wstrb);
      end
    end
    @(negedge clk); m_ack = 0; m_rvalid = 1; m_rdata = 32'h55555555; #1;
    n_cmp++; if ({d_rvalid, d_rdata, m_req} !== {1'b1, 32'h0, 1'b0}) begin n_err++; $display("FAIL store_rsp: got dv=%b dd=%h mreq=%b exp 1 0 0", d_rvalid, d_rdata, m_req); end
    @(negedge clk); m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic test_guard;
    int cnt;
    logic exp_if;
    cnt = 0;
    for (int g = 0; g < 15; g++) begin
      @(negedge clk); m_rvalid = 0; if_req = 1; d_req = 1; d_wr = 0; d_addr = 32'h1C003000 + 32'(g); if_addr = 32'h1C000100; #1;
      exp_if = GUARD && cnt == LIMIT;
      n_cmp++; if ({if_ready, d_ready} !== {exp_if, !exp_if}) begin n_err++; $display("FAIL guard_grant[%0d]: got %b exp %b", g, {if_ready, d_ready}, {exp_if, !exp_if}); end
      cnt = exp_if ? 0 : (cnt < LIMIT ? cnt + 1 : cnt);
      @(negedge clk); m_ack = 1;
      @(negedge clk); m_ack = 0; m_rvalid = 1;
    end
    @(negedge clk); m_rvalid = 0; if_req = 0; d_req = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); d_req = 1; d_wr = 1; d_addr = 32'h1C003000; d_wdata = 32'h01020304; d_wstrb = 4'h3; #1;
    n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL rmid_grant: got drdy=%b exp 1", d_ready); end
    @(negedge clk); d_req = 0; #1;
    n_cmp++; if (m_req !== 1'b1) begin n_err++; $display("FAIL rmid_req: got mreq=%b exp 1", m_req); end
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D; d_req = 1; d_wr = 0; d_addr = 32'h1C004000; #1;
    n_cmp++; if ({m_req, m_wr, m_addr} !== 34'h0) begin n_err++; $display("FAIL rmid_idle: got req=%b wr=%b addr=%h exp 0 0 0", m_req, m_wr, m_addr); end
    n_cmp++; if ({if_rvalid, d_rvalid, d_rdata} !== 34'h0) begin n_err++; $display("FAIL rmid_stale: got ifv=%b dv=%b dd=%h exp 0 0 0", if_rvalid, d_rvalid, d_rdata); end
    n_cmp++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL rmid_regrant: got drdy=%b exp 1", d_ready); end
    serve();
  endtask

  task automatic test_random;
    int cnt, ackd, rspd;
    logic ir, dr, fl, gi, gd, drop, wr;
    logic [31:0] ea, ew, rd;
    logic [3:0] es;
    cnt = 0;
    @(negedge clk); if_req = 0; d_req = 0; if_flush = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      m_ack = 0; m_rvalid = 0;
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); fl = ($urandom_range(0, 3) == 0);
      if_req = ir; if_flush = fl; if_addr = $urandom; d_req = dr; d_wr = 1'($urandom_range(0, 1));
      d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom_range(0, 15));
      #1;
      gd = dr && !(GUARD && cnt == LIMIT && ir && !fl);
      gi = ir && !fl && !gd;
      n_cmp++; if ({if_ready, d_ready} !== {gi, gd}) begin n_err++; $display("FAIL rand_grant[%0d]: got %b exp %b", n, {if_ready, d_ready}, {gi, gd}); end
      if (gi) cnt = 0;
      else if (gd && ir && !fl) cnt = cnt < LIMIT ? cnt + 1 : cnt;
      else if (!ir) cnt = 0;
      if (!gi && !gd) continue;
      wr = gd && d_wr; ea = gd ? d_addr : if_addr; ew = d_wdata; es = d_wstrb; drop = 0;
      ackd = $urandom_range(0, 3); rspd = $urandom_range(0, 3);
      for (int k = 0; k <= ackd; k++) begin
        @(negedge clk);
        m_ack = (k == ackd); m_rvalid = 1'($urandom_range(0, 1)); m_rdata = $urandom;
        if_flush = ($urandom_range(0, 3) == 0); if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        drop = drop || (gi && if_flush);
        #1;
        n_cmp++;
        if (m_req !== 1'b1 || m_wr !== wr || m_addr !== ea || (wr && {m_wdata, m_wstrb} !== {ew, es}) || {if_ready, d_ready, if_rvalid, d_rvalid} !== 4'b0) begin
          n_err++; $display("FAIL rand_req[%0d]: got req=%b wr=%b addr=%h wdata=%h wstrb=%h rdy=%b%b rv=%b%b exp 1 %b %h %h %h 00 00", n, m_req, m_wr, m_addr, m_wdata, m_wstrb, if_ready, d_ready, if_rvalid, d_rvalid, wr, ea, ew, es);
        end
      end
      for (int k = 0; k < rspd; k++) begin
        @(negedge clk);
        m_ack = 0; m_rvalid = 0; if_flush = ($urandom_range(0, 3) == 0);
        if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
        drop = drop || (gi && if_flush);
        #1;
        n_cmp++; if ({m_req, if_ready, d_ready, if_rvalid, d_rvalid} !== 5'b0) begin n_err++; $display("FAIL rand_wait[%0d]: got %b exp 00000", n, {m_req, if_ready, d_ready, if_rvalid, d_rvalid}); end
      end
      @(negedge clk);
      m_ack = 0; m_rvalid = 1; rd = $urandom; m_rdata = rd; if_flush = 0;
      if_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if ({if_rvalid, if_rdata, d_rvalid, d_rdata, if_ready, d_ready, m_req} !== {gi && !drop, (gi && !drop) ? rd : 32'h0, gd, (gd && !wr) ? rd : 32'h0, 3'b000}) begin
        n_err++; $display("FAIL rand_rsp[%0d]: got ifv=%b ifd=%h dv=%b dd=%h rdy=%b%b mreq=%b exp %b %h %b %h 00 0", n, if_rvalid, if_rdata, d_rvalid, d_rdata, if_ready, d_ready, m_req, gi && !drop, (gi && !drop) ? rd : 32'h0, gd, (gd && !wr) ? rd : 32'h0);
      end
    end
    @(negedge clk); m_rvalid = 0; m_ack = 0; if_req = 0; d_req = 0; if_flush = 0;
  endtask

  initial begin
    rst_n = 0; if_req = 0; if_addr = 0; if_flush = 0; d_req = 0; d_wr = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; m_ack = 0; m_rvalid = 0; m_rdata = 0;
    test_reset();
    test_lone_fetch();
    test_collision();
    test_flush_drop();
    test_store_delay();
    test_guard();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
